encoder_42: RTL



---
 rtl/encoder_pkg.sv | 35 +++
 rtl/sync_debounce.sv | 49 ++++
 rtl/encoder_42.sv | 81 ++++++++
 3 files changed

// File: rtl/encoder_pkg.sv
// Shared types and helpers for the registered 4-to-2 encoder.
package encoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_FAULT
  } state_t;

  localparam logic [1:0] CODE_0 = 2'd0;
  localparam logic [1:0] CODE_1 = 2'd1;
  localparam logic [1:0] CODE_2 = 2'd2;
  localparam logic [1:0] CODE_3 = 2'd3;

  typedef struct packed {
    logic       onehot;
    logic [1:0] code;
  } enc_t;

  // Anything that is not exactly one bit set reports onehot=0 and code 00.
  function automatic enc_t encode(input logic [3:0] value);
    enc_t result;
    result.onehot = 1'b1;
    result.code   = CODE_0;
    case (value)
      4'b0001: result.code = CODE_0;
      4'b0010: result.code = CODE_1;
      4'b0100: result.code = CODE_2;
      4'b1000: result.code = CODE_3;
      default: result.onehot = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a stability counter; accept pulses once per
// candidate that has held for N synchronized cycles.
module sync_debounce #(
  parameter int WIDTH = 4,
  parameter int N     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable_val,
  output logic             accept
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] cand;
  logic [CW-1:0]    cnt;
  logic             done;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      s    <= '0;
      cand <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      meta <= raw;
      s    <= meta;
      if (s != cand) begin
        cand <= s;
        cnt  <= '0;
        done <= 1'b0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end else begin
        // cnt is saturated; remember that this candidate was already handed on
        done <= 1'b1;
      end
    end
  end

  assign accept     = (s == cand) && (cnt == CNT_MAX) && !done;
  assign stable_val = cand;

endmodule

// File: rtl/encoder_42.sv
// Registered 4-to-2 encoder: debounced one-hot lines become a code with
// valid, change strobe and multi-hot error flags.
module encoder_42
  import encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in,
  output logic [1:0] out,
  output logic       valid,
  output logic       strobe,
  output logic       err
);

  logic [3:0] stable_val;
  logic       accept;
  state_t     state;
  state_t     state_n;
  logic [1:0] out_n;
  logic       valid_n;
  logic       strobe_n;
  logic       err_n;
  enc_t       enc;

  sync_debounce #(
    .WIDTH(4),
    .N    (DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .clk       (clk),
    .rst       (rst),
    .raw       (in),
    .stable_val(stable_val),
    .accept    (accept)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      out    <= CODE_0;
      valid  <= 1'b0;
      strobe <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      out    <= out_n;
      valid  <= valid_n;
      strobe <= strobe_n;
      err    <= err_n;
    end
  end

  // out is left alone outside ACTIVE so it keeps the last valid code.
  always_comb begin
    state_n  = state;
    out_n    = out;
    valid_n  = valid;
    strobe_n = 1'b0;
    err_n    = err;
    enc      = encode(stable_val);
    if (accept) begin
      if (stable_val == 4'b0000) begin
        state_n = ST_IDLE;
        valid_n = 1'b0;
        err_n   = 1'b0;
      end else if (enc.onehot) begin
        state_n  = ST_ACTIVE;
        valid_n  = 1'b1;
        err_n    = 1'b0;
        out_n    = enc.code;
        strobe_n = (state != ST_ACTIVE) || (enc.code != out);
      end else begin
        state_n = ST_FAULT;
        valid_n = 1'b0;
        err_n   = 1'b1;
      end
    end
  end

endmodule
